// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Writeback request bus shared by all requesters of the register-file write
// port. Requester i occupies bit i of req_valid/req_ready, bits [i*AW +: AW]
// of req_addr and bits [i*DW +: DW] of req_data.
//
// Signals:
//   req_valid  NREQ     per-requester write request
//   req_addr   NREQ*AW  packed destination register addresses
//   req_data   NREQ*DW  packed write data
//   req_ready  NREQ     one-hot grant back to the requesters
//
// Modports:
//   master  requester side (drives valid/addr/data, sees ready)
//   slave   arbiter side   (sees valid/addr/data, drives ready)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port (A3/WD3/WE3) between NREQ
// writeback requesters (ALU, load unit, debug). The debug requester is index
// NREQ-1. Requests are granted round-robin with a valid/ready handshake and
// the accepted write is presented to the regfile through a registered output
// stage one cycle later. A halt state machine drains the output stage and then
// admits only the debug requester until halt_req drops.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   req          request bus (slave modport): req_valid, req_addr, req_data,
//                req_ready (combinational one-hot grant)
//   rf_we        regfile WE3, registered
//   rf_a3        regfile A3, registered
//   rf_wd        regfile WD3, registered
//   grant_id     index of the last accepted requester, registered
//   halt_req     level request to enter debug-only mode
//   halt_ack     high while the arbiter is halted, registered
//
// Optional feature (macro REGFILE_WB_ARB_STATS_EN):
//   stat_grants  NREQ*16 per-requester saturating transfer counters
//   stat_stalls  16-bit saturating count of cycles with a pending request but
//                no transfer
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter  int NREQ = 3,
  parameter  int AW   = 5,
  parameter  int DW   = 32,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   req,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_a3,
  output logic [DW-1:0]         rf_wd,
  output logic [IDW-1:0]        grant_id,
  input  logic                  halt_req,
  output logic                  halt_ack
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    stat_grants,
  output logic [15:0]           stat_stalls
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_ptr_next;
  logic [NREQ-1:0] eligible;
  logic            grant_hit;
  logic [IDW-1:0]  grant_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Halt state register; halt_ack is registered from the next state so it is
  // high exactly on the cycles spent in HALTED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      halt_ack <= 1'b0;
    end else begin
      state    <= state_next;
      halt_ack <= (state_next == HALTED);
    end
  end

  // DRAIN always lasts one cycle so the write already in the output stage
  // retires before the debug requester gets the port, even if halt_req drops.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (halt_req) state_next = DRAIN;
      DRAIN:   state_next = HALTED;
      HALTED:  if (!halt_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    eligible = '0;
    case (state)
      RUN:     eligible = '1;
      HALTED:  eligible[NREQ-1] = 1'b1;
      default: eligible = '0;
    endcase
  end

  // Round-robin search starting at rr_ptr. The sum is one bit wider than the
  // pointer so the modulo wrap is a single conditional subtract.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    grant_hit     = 1'b0;
    grant_idx     = '0;
    sum           = '0;
    idx           = '0;
    req.req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!grant_hit && eligible[idx] && req.req_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_hit) begin
      req.req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_addr = req.req_addr[i*AW +: AW];
        sel_data = req.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    if (grant_idx == IDW'(NREQ-1)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = grant_idx + IDW'(1);
    end
  end

  // Output stage. A write to x0 is still a completed transfer (pointer and
  // grant_id move on) but must never assert the regfile write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_a3    <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (grant_hit) begin
      rf_we    <= (sel_addr != '0);
      rf_a3    <= sel_addr;
      rf_wd    <= sel_data;
      grant_id <= grant_idx;
      rr_ptr   <= rr_ptr_next;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef REGFILE_WB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_hit && grant_idx == IDW'(i) &&
            stat_grants[i*16 +: 16] != 16'hFFFF) begin
          stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
        end
      end
      if ((|req.req_valid) && !grant_hit && stat_stalls != 16'hFFFF) begin
        stat_stalls <= stat_stalls + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (A3/WD3/WE3) between NREQ writeback requesters: ALU, load unit and debug, with debug as the highest index.
- Round-robin arbitration with valid/ready handshakes.
- Registered output stage that drives the regfile write port directly.
- Debug halt state machine that drains the write stage, then admits only the debug requester.

Parameters:
- NREQ, 3, number of requesters; index NREQ-1 is the debug requester.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed destination register; requester i occupies [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; requester i occupies [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant, combinational
- rf_we  out  1  to regfile WE3, registered
- rf_a3  out  AW  to regfile A3, registered
- rf_wd  out  DW  to regfile WD3, registered
- grant_id  out  $clog2(NREQ)  index of last accepted requester, registered
- halt_req  in  1  level request to enter debug-only mode
- halt_ack  out  1  high while in HALTED, registered

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - rf_we=0, rf_a3=0, rf_wd=0, grant_id=0, halt_ack=0.
  - rr_ptr=0, state=RUN.
  - Statistics counters 0 when compiled in.
- Handshake:
  - Transfer on req_valid[i] & req_ready[i].
  - At most one req_ready bit is high per cycle.
  - req_ready may depend on req_valid.
  - A requester must hold valid, addr and data stable until accepted.
- Eligibility:
  - RUN: all requesters are eligible.
  - DRAIN: no requester is eligible.
  - HALTED: only index NREQ-1 is eligible.
- Round-robin:
  - Search eligible valid requesters starting at rr_ptr, wrapping modulo NREQ; the first hit is granted.
  - On transfer by i, rr_ptr <= (i+1) mod NREQ.
  - With no transfer, rr_ptr holds.
- Output stage (1-cycle latency):
  - On the edge after a transfer: rf_we=1, rf_a3=addr, rf_wd=data, grant_id=i.
  - With no transfer on that edge: rf_we=0; rf_a3, rf_wd and grant_id hold.
  - The regfile commits on the following edge.
- x0 writes: a transfer with addr==0 completes normally and updates grant_id and rr_ptr, but rf_we stays 0.
- Same-address collisions: resolved purely by arbitration; the loser waits. There is no write merging.
- State machine:
  - RUN & halt_req -> DRAIN.
  - DRAIN -> HALTED unconditionally after 1 cycle, which lets the in-flight output-stage write retire.
  - HALTED & !halt_req -> RUN.
  - A halt_req drop while in DRAIN still passes through HALTED for one cycle.
- halt_ack is registered: it equals 1 on the cycles when state==HALTED.
- Reset mid-operation: all state clears immediately, rf_we drops asynchronously, and any in-flight write is lost.

Optional Feature:
- Macro REGFILE_WB_ARB_STATS_EN.
- When defined, the block adds:
  - Output stat_grants, NREQ*16 bits: per-requester 16-bit saturating transfer counters.
  - Output stat_stalls, 16 bits: saturating count of cycles where some req_valid is high but no transfer occurs.
- All counters reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single requester: req 0 valid, addr=5, data=32'hDEAD_BEEF -> req_ready[0]=1 the same cycle; the next cycle rf_we=1, rf_a3=5, rf_wd=DEAD_BEEF, grant_id=0.
- Round-robin fairness: all 3 requesters valid continuously after reset -> grants 0,1,2,0,1,2; rf_we=1 every cycle from the second cycle on.
- x0 suppression: req 1 writes addr=0, data=7 -> handshake completes and grant_id=1, but rf_we stays 0; rr_ptr advances so requester 2 wins the next contention.
- Halt sequence: halt_req=1 while reqs 0 and 2 are valid:
  - DRAIN cycle: no ready asserted.
  - Then halt_ack=1; only req 2 (debug) is granted; req 0 stalls.
  - Drop halt_req -> RUN, and req 0 is granted.
- Async reset mid-write: assert rst_n=0 while rf_we=1 -> rf_we, halt_ack and grant_id go to 0 immediately; after release, the first grant goes to requester 0.
- Statistics (REGFILE_WB_ARB_STATS_EN): hold req 0 valid through 3 DRAIN/HALTED cycles and then grant it -> stat_stalls=3 and stat_grants for req 0 = 1.
